sfifo_pop_reader: RTL and testbench
===================================

# sfifo_pop_reader

Read-side bridge for the synchronous BRAM FIFO wrappers (f1024x36, f2048x18, f4096x9). Issues POP to the FIFO whenever downstream space is guaranteed, captures the read data after the fixed FIFO read latency into a small skid buffer, and presents it on a valid/ready stream. Supports a controlled stop (Drain) that lets in-flight words land before reporting idle, and keeps word and error counters for bring-up and tests.

## Interface
- DATA_WIDTH, 36: FIFO DOUT width; 36, 18 or 9.
- READ_LATENCY, 1: cycles from POP sampled to DOUT valid; legal values 1 or 2.
- CNT_WIDTH, 16: width of Word_Count.

- clock0  in  1  single clock, all logic on rising edge.
- Flush  in  1  synchronous, active-high reset; also flushes skid buffer and in-flight tracking.
- FIFO_DOUT  in  DATA_WIDTH  FIFO read data.
- FIFO_Empty  in  1  FIFO empty flag, already updated for a POP sampled on the same edge.
- FIFO_Underrun  in  1  FIFO Underrun_Error.
- POP  out  1  FIFO pop request.
- M_DATA  out  DATA_WIDTH  stream data.
- M_VALID  out  1  stream valid.
- M_READY  in  1  stream ready.
- Drain  in  1  level; while high, no new POPs are issued.
- Drain_Done  out  1  high in STOPPED state.
- Word_Count  out  CNT_WIDTH  words accepted downstream (M_VALID & M_READY), wraps modulo 2^CNT_WIDTH.
- Underrun_Seen  out  1  sticky: POP issued with FIFO_Empty high, or FIFO_Underrun seen.

## Operation
- Skid buffer depth D = READ_LATENCY + 1 entries, FIFO-ordered.
- Credit rule: POP = RUN & !FIFO_Empty & (occupancy + inflight + pops_this_cycle_not_yet_counted) < D, where occupancy counts buffer entries remaining after this cycle's M_VALID & M_READY. POP is combinational from registered state plus M_READY and FIFO_Empty.
- In-flight tracking: READ_LATENCY-stage shift register of POP; FIFO_DOUT written into buffer when the last stage is 1. No word is ever dropped or duplicated.
- Output: M_VALID = buffer non-empty; M_DATA = head entry; M_DATA holds steady while M_VALID & !M_READY.
- State machine:
  - RUN: issue POPs per credit rule. Drain=1 -> STOP_WAIT.
  - STOP_WAIT: POP=0. Inflight==0 and buffer empty -> STOPPED. Drain=0 -> RUN.
  - STOPPED: Drain_Done=1, POP=0. Drain=0 -> RUN.
- Underrun_Seen set on POP & FIFO_Empty (never occurs in a correct implementation; checker) or FIFO_Underrun; cleared only by Flush.

## Timing
- Reset values (Flush high at edge): POP=0, M_VALID=0, M_DATA=0, Drain_Done=0, Word_Count=0, Underrun_Seen=0, state=RUN, buffer and in-flight cleared.
- Flush mid-operation: words in flight are discarded; FIFO_DOUT arriving in the following READ_LATENCY cycles is ignored. POP is 0 in the cycle Flush is high.
- Latency FIFO-to-stream: POP at edge n -> M_VALID at edge n+READ_LATENCY (buffer empty, M_READY=1).
- Throughput: one word per cycle sustained with M_READY held high and FIFO non-empty.
- M_READY low: POPs stop once occupancy + inflight reaches D; resuming M_READY re-enables POP in the same cycle.
- Simultaneous buffer write and read in one cycle: occupancy unchanged; both allowed when full.
- Drain asserted with POP same cycle: that POP still counts as in-flight and its word is delivered before STOPPED.

## Structure
- Package sfifo_rd_pkg: state enum (RUN, STOP_WAIT, STOPPED), localparam for skid depth function of READ_LATENCY, max occupancy width.
- Sub-module sfifo_rd_skid: D-entry register FIFO with write, read, occupancy; no flags beyond count.
- Top holds credit logic, in-flight shift register, state machine, counters.

## Test plan
- Streaming: FIFO preloaded with 1024 words a|(a<<20)|0x55000 (masked to DATA_WIDTH), M_READY=1 -> 1024 in-order words, first M_VALID READ_LATENCY cycles after first POP, Word_Count=1024, Underrun_Seen=0.
- Backpressure: M_READY toggled 1-cycle-on/2-off pseudo-randomly over 256 words -> no loss/duplication, M_DATA stable while stalled, occupancy never exceeds D.
- Empty boundary: FIFO holds 3 words, M_READY=1 -> exactly 3 POPs, then POP=0, M_VALID deasserts, Underrun_Seen stays 0.
- Drain: Drain raised with 2 words in flight (READ_LATENCY=2) -> both delivered, Drain_Done high one cycle after buffer empties; Drain low -> POP resumes next cycle.
- Flush mid-stream: Flush for 1 cycle after 10 words with in-flight pop -> outputs at reset values, late FIFO_DOUT not delivered, Word_Count=0.
- Counter wrap: CNT_WIDTH=4, 20 words -> Word_Count=4.

Source files
------------

// File: rtl/sfifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO read-side bridge.
package sfifo_rd_pkg;

    // Control states of the pop issuer
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STOP_WAIT = 2'd1,
        ST_STOPPED   = 2'd2
    } rd_state_t;

    // Largest supported FIFO read latency
    localparam int MAX_READ_LATENCY = 2;

    // Occupancy counter width: must hold 0..(MAX_READ_LATENCY + 1)
    localparam int OCC_W = $clog2(MAX_READ_LATENCY + 2);

    // Skid buffer depth: one entry per in-flight read plus one being presented
    function automatic int skid_depth(input int read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/sfifo_rd_skid.sv
// Small register FIFO that absorbs words already requested from the BRAM FIFO.
module sfifo_rd_skid #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 2,
    parameter int OCC_W      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [OCC_W-1:0]      o_occ
);

    localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic                  w_do_rd;

    // A read against an empty buffer is ignored
    assign w_do_rd = i_rd & (r_occ != '0);

    // Pointer and occupancy bookkeeping; a write and a read in one cycle leave occupancy unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_wr) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_occ <= r_occ + OCC_W'(i_wr) - OCC_W'(w_do_rd);
        end
    end

    // Storage write; contents need no reset because occupancy gates visibility
    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/sfifo_pop_reader.sv
// Read-side bridge: pops the BRAM FIFO only when the skid buffer is guaranteed
// room for the returning word, and presents buffered words on a valid/ready stream.
module sfifo_pop_reader
    import sfifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH   = 36,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clock0,
    input  logic                  Flush,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    input  logic                  FIFO_Empty,
    input  logic                  FIFO_Underrun,
    output logic                  POP,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    input  logic                  Drain,
    output logic                  Drain_Done,
    output logic [CNT_WIDTH-1:0]  Word_Count,
    output logic                  Underrun_Seen
);

    localparam int               DEPTH   = skid_depth(READ_LATENCY);
    localparam int               SUM_W   = OCC_W + 2;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

    rd_state_t               r_state;
    logic                    r_drain_done;
    logic [READ_LATENCY-1:0] r_inflight;
    logic [CNT_WIDTH-1:0]    r_word_count;
    logic                    r_underrun_seen;

    logic [OCC_W-1:0]        w_occ;
    logic [DATA_WIDTH-1:0]   w_head;
    logic                    w_valid;
    logic                    w_accept;
    logic                    w_land;
    logic                    w_pop;
    logic [SUM_W-1:0]        w_inflight_cnt;
    logic [SUM_W-1:0]        w_committed;

    assign w_valid  = (w_occ != '0);
    assign w_accept = w_valid & M_READY;
    // The oldest in-flight pop has its data on FIFO_DOUT this cycle
    assign w_land   = r_inflight[READ_LATENCY-1];

    // Entries the buffer is committed to after this cycle's read: what stays plus what is still coming
    always_comb begin
        w_inflight_cnt = '0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            w_inflight_cnt = w_inflight_cnt + SUM_W'(r_inflight[k]);
        end
        w_committed = SUM_W'(w_occ) - SUM_W'(w_accept) + w_inflight_cnt;
    end

    assign w_pop = (r_state == ST_RUN) & ~Flush & ~FIFO_Empty & (w_committed < DEPTH_S);

    sfifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .OCC_W      (OCC_W)
    ) u_skid (
        .i_clk   (clock0),
        .i_rst   (Flush),
        .i_wr    (w_land),
        .i_wdata (FIFO_DOUT),
        .i_rd    (w_accept),
        .o_head  (w_head),
        .o_occ   (w_occ)
    );

    // Track each pop until its data lands; Flush forgets pops already issued
    always_ff @(posedge clock0) begin
        if (Flush) begin
            r_inflight <= '0;
        end else begin
            r_inflight[0] <= w_pop;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_inflight[k] <= r_inflight[k-1];
            end
        end
    end

    // Run / drain control; STOPPED is reached only once nothing is buffered or in flight
    always_ff @(posedge clock0) begin
        if (Flush) begin
            r_state      <= ST_RUN;
            r_drain_done <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_drain_done <= 1'b0;
                    if (Drain) begin
                        r_state <= ST_STOP_WAIT;
                    end
                end
                ST_STOP_WAIT: begin
                    if (!Drain) begin
                        r_state      <= ST_RUN;
                        r_drain_done <= 1'b0;
                    end else if ((r_inflight == '0) && (w_occ == '0)) begin
                        r_state      <= ST_STOPPED;
                        r_drain_done <= 1'b1;
                    end
                end
                ST_STOPPED: begin
                    if (!Drain) begin
                        r_state      <= ST_RUN;
                        r_drain_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_drain_done <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted words (wrapping) and latch any underrun indication
    always_ff @(posedge clock0) begin
        if (Flush) begin
            r_word_count    <= '0;
            r_underrun_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if ((w_pop & FIFO_Empty) | FIFO_Underrun) begin
                r_underrun_seen <= 1'b1;
            end
        end
    end

    assign POP           = w_pop;
    assign M_VALID       = w_valid;
    assign M_DATA        = w_valid ? w_head : '0;
    assign Drain_Done    = r_drain_done;
    assign Word_Count    = r_word_count;
    assign Underrun_Seen = r_underrun_seen;

endmodule

// File: tb/tb_sfifo_pop_reader.sv
// Bench for sfifo_pop_reader: instance 0 uses READ_LATENCY=1/CNT_WIDTH=16,
// instance 1 uses READ_LATENCY=2/CNT_WIDTH=4; both see the same FIFO contents and stimulus.
module tb_sfifo_pop_reader;

    localparam int DW    = 36;
    localparam int NI    = 2;
    localparam int MEMSZ = 2048;
    localparam logic [DW-1:0] JUNK = 36'hBADBADBAD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic flush, m_ready, drain, und_inj;
    logic          pop    [NI];
    logic [DW-1:0] mdata  [NI];
    logic          mvalid [NI];
    logic          ddone  [NI];
    logic          useen  [NI];
    logic          empty  [NI];
    logic [15:0]   wc_a;
    logic [3:0]    wc_b;

    // FIFO model: shared contents, one read pointer per instance
    logic [DW-1:0] fmem [MEMSZ];
    int            fwr = 0;
    int            frd [NI] = '{0, 0};
    logic [DW-1:0] rd_a, rd_b1, rd_b2;

    assign empty[0] = (frd[0] == fwr);
    assign empty[1] = (frd[1] == fwr);

    sfifo_pop_reader #(.DATA_WIDTH(DW), .READ_LATENCY(1), .CNT_WIDTH(16)) dut_a (
        .clock0(clk), .Flush(flush), .FIFO_DOUT(rd_a), .FIFO_Empty(empty[0]),
        .FIFO_Underrun(und_inj), .POP(pop[0]), .M_DATA(mdata[0]), .M_VALID(mvalid[0]),
        .M_READY(m_ready), .Drain(drain), .Drain_Done(ddone[0]), .Word_Count(wc_a),
        .Underrun_Seen(useen[0]));

    sfifo_pop_reader #(.DATA_WIDTH(DW), .READ_LATENCY(2), .CNT_WIDTH(4)) dut_b (
        .clock0(clk), .Flush(flush), .FIFO_DOUT(rd_b2), .FIFO_Empty(empty[1]),
        .FIFO_Underrun(und_inj), .POP(pop[1]), .M_DATA(mdata[1]), .M_VALID(mvalid[1]),
        .M_READY(m_ready), .Drain(drain), .Drain_Done(ddone[1]), .Word_Count(wc_b),
        .Underrun_Seen(useen[1]));

    // BRAM FIFO read port: data appears READ_LATENCY cycles after POP, garbage otherwise
    always @(posedge clk) begin
        if (pop[0] && !empty[0]) begin
            rd_a   <= fmem[frd[0] % MEMSZ];
            frd[0] <= frd[0] + 1;
        end else begin
            rd_a <= JUNK;
        end
        if (pop[1] && !empty[1]) begin
            rd_b1  <= fmem[frd[1] % MEMSZ];
            frd[1] <= frd[1] + 1;
        end else begin
            rd_b1 <= JUNK;
        end
        rd_b2 <= rd_b1;
    end

    // Stream-level model: words available = popped words whose latency elapsed - accepted words
    int exp_idx [NI] = '{0, 0};
    int avail   [NI] = '{0, 0};
    int wcnt    [NI] = '{0, 0};
    bit mus     [NI] = '{0, 0};
    bit hist    [NI][2];

    always @(posedge clk) begin
        int acc;
        int arr;
        for (int i = 0; i < NI; i++) begin
            if (flush) begin
                exp_idx[i] <= frd[i];
                avail[i]   <= 0;
                wcnt[i]    <= 0;
                mus[i]     <= 1'b0;
                hist[i][0] <= 1'b0;
                hist[i][1] <= 1'b0;
            end else begin
                acc = (mvalid[i] && m_ready) ? 1 : 0;
                arr = ((i == 0) ? hist[i][0] : hist[i][1]) ? 1 : 0;
                avail[i]   <= avail[i] + arr - acc;
                exp_idx[i] <= exp_idx[i] + acc;
                wcnt[i]    <= wcnt[i] + acc;
                hist[i][0] <= pop[i];
                hist[i][1] <= hist[i][0];
                if ((pop[i] && empty[i]) || und_inj) mus[i] <= 1'b1;
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int a);
        logic [63:0] v;
        v = 64'(a) | (64'(a) << 20) | 64'h55000;
        return v[DW-1:0];
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < NI; i++) begin
                int depth;
                int wexp;
                int wact;
                depth = (i == 0) ? 2 : 3;
                chk(mvalid[i] == (avail[i] > 0), $sformatf("m_valid[%0d]", i), mvalid[i], avail[i] > 0);
                if (mvalid[i])
                    chk(mdata[i] == fmem[exp_idx[i] % MEMSZ], $sformatf("m_data[%0d]", i),
                        mdata[i], fmem[exp_idx[i] % MEMSZ]);
                wact = (i == 0) ? int'(wc_a) : int'(wc_b);
                wexp = (i == 0) ? (wcnt[0] & 16'hFFFF) : (wcnt[1] & 4'hF);
                chk(wact == wexp, $sformatf("word_count[%0d]", i), wact, wexp);
                chk(useen[i] == mus[i], $sformatf("underrun_seen[%0d]", i), useen[i], mus[i]);
                chk(!(pop[i] && empty[i]), $sformatf("pop_on_empty[%0d]", i), pop[i], 0);
                chk(avail[i] <= depth, $sformatf("occupancy[%0d]", i), avail[i], depth);
                if (ddone[i])
                    chk(!pop[i] && avail[i] == 0 && !hist[i][0] && !(i == 1 && hist[i][1]),
                        $sformatf("stopped_idle[%0d]", i), pop[i], 0);
                if (flush) chk(!pop[i], $sformatf("pop_in_flush[%0d]", i), pop[i], 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            fmem[fwr % MEMSZ] = word_of(fwr);
            fwr++;
        end
    endtask

    task automatic wait_words(input int ta, input int tb, input int budget, input string nm);
        int c;
        c = 0;
        while (!(wcnt[0] >= ta && wcnt[1] >= tb) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(c < budget, {nm, "_timeout"}, c, budget);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (!(frd[0] == fwr && frd[1] == fwr && avail[0] == 0 && avail[1] == 0 &&
                 !hist[0][0] && !hist[1][0] && !hist[1][1]) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(c < budget, "idle_timeout", c, budget);
    endtask

    initial begin
        int fp [NI];
        int fv [NI];
        int np [NI];
        int lmv [NI];
        int fdd [NI];
        int c;
        int base_b;

        flush = 1'b1; m_ready = 1'b0; drain = 1'b0; und_inj = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(pop[i] == 1'b0,    $sformatf("rst_pop[%0d]", i), pop[i], 0);
            chk(mvalid[i] == 1'b0, $sformatf("rst_mvalid[%0d]", i), mvalid[i], 0);
            chk(mdata[i] == '0,    $sformatf("rst_mdata[%0d]", i), mdata[i], 0);
            chk(ddone[i] == 1'b0,  $sformatf("rst_ddone[%0d]", i), ddone[i], 0);
            chk(useen[i] == 1'b0,  $sformatf("rst_useen[%0d]", i), useen[i], 0);
        end
        chk(wc_a == 16'd0, "rst_wc_a", wc_a, 0);
        chk(wc_b == 4'd0, "rst_wc_b", wc_b, 0);
        run_chk = 1'b1;
        step();
        flush = 1'b0;

        // Streaming: 1024 words with M_READY held high
        m_ready = 1'b1;
        load(1024);
        fp = '{-1, -1}; fv = '{-1, -1};
        c = 0;
        while (!(wcnt[0] >= 1024 && wcnt[1] >= 1024) && c < 4000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (pop[i] && fp[i] < 0) fp[i] = c;
                if (mvalid[i] && fv[i] < 0) fv[i] = c;
            end
            c++;
        end
        chk(c < 4000, "stream_timeout", c, 4000);
        chk(fv[0] - fp[0] == 2, "latency_rl1", fv[0] - fp[0], 2);
        chk(fv[1] - fp[1] == 3, "latency_rl2", fv[1] - fp[1], 3);
        @(negedge clk);
        chk(wc_a == 16'd1024, "stream_wc_a", wc_a, 1024);
        chk(wc_b == 4'd0, "stream_wc_b", wc_b, 0);
        chk(useen[0] == 1'b0 && useen[1] == 1'b0, "stream_useen", useen[0] | useen[1], 0);

        // Backpressure: 256 words with M_READY roughly one cycle in three
        step();
        load(256);
        c = 0;
        while (!(wcnt[0] >= 1280 && wcnt[1] >= 1280) && c < 3000) begin
            m_ready = ($urandom_range(0, 2) == 0);
            step();
            c++;
        end
        chk(c < 3000, "bp_timeout", c, 3000);
        m_ready = 1'b1;
        @(negedge clk);
        chk(wc_a == 16'd1280, "bp_wc_a", wc_a, 1280);
        wait_idle(50);

        // Empty boundary: exactly three pops for three words
        step();
        load(3);
        np = '{0, 0};
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (pop[i]) np[i]++;
        end
        chk(np[0] == 3, "empty_pops_a", np[0], 3);
        chk(np[1] == 3, "empty_pops_b", np[1], 3);
        chk(!mvalid[0] && !mvalid[1], "empty_mvalid", mvalid[0] | mvalid[1], 0);
        chk(!useen[0] && !useen[1], "empty_useen", useen[0] | useen[1], 0);

        // Underrun flag from the FIFO is latched
        step();
        und_inj = 1'b1;
        step();
        und_inj = 1'b0;
        @(negedge clk);
        chk(useen[0] && useen[1], "underrun_latched", useen[0] & useen[1], 1);

        // Drain with reads in flight
        step();
        load(50);
        repeat (8) @(negedge clk);
        chk(hist[1][0] && hist[1][1], "b_two_inflight", {hist[1][0], hist[1][1]}, 2'b11);
        step();
        drain = 1'b1;
        lmv = '{-1, -1}; fdd = '{-1, -1};
        c = 0;
        while (!(fdd[0] >= 0 && fdd[1] >= 0) && c < 40) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (mvalid[i]) lmv[i] = c;
                if (ddone[i] && fdd[i] < 0) fdd[i] = c;
            end
            c++;
        end
        chk(c < 40, "drain_timeout", c, 40);
        chk(fdd[0] - lmv[0] == 2, "drain_done_a", fdd[0] - lmv[0], 2);
        chk(fdd[1] - lmv[1] == 2, "drain_done_b", fdd[1] - lmv[1], 2);
        repeat (3) begin
            @(negedge clk);
            chk(!pop[0] && !pop[1], "drain_no_pop", pop[0] | pop[1], 0);
        end
        step();
        drain = 1'b0;
        @(negedge clk);
        chk(!pop[0] && !pop[1] && ddone[0] && ddone[1], "drain_release_hold",
            {pop[0], pop[1], ddone[0], ddone[1]}, 4'b0011);
        @(negedge clk);
        chk(pop[0] && pop[1], "drain_resume_pop", {pop[0], pop[1]}, 2'b11);

        // Flush mid-stream with a pop in flight
        base_b = wcnt[1];
        wait_words(0, base_b + 10, 100, "flush_pre");
        c = 0;
        while (!pop[1] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk(c < 20, "flush_pop_timeout", c, 20);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk(!pop[0] && !pop[1], "flush_pop", pop[0] | pop[1], 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk(!mvalid[i], $sformatf("flush_mvalid[%0d]", i), mvalid[i], 0);
            chk(!ddone[i], $sformatf("flush_ddone[%0d]", i), ddone[i], 0);
            chk(!useen[i], $sformatf("flush_useen[%0d]", i), useen[i], 0);
        end
        chk(wc_a == 16'd0 && wc_b == 4'd0, "flush_wc", {wc_a, wc_b}, 0);
        wait_idle(200);

        // Counter wrap: 20 words into a 4-bit counter
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        load(20);
        wait_words(20, 20, 200, "wrap");
        @(negedge clk);
        chk(wc_a == 16'd20, "wrap_wc_a", wc_a, 20);
        chk(wc_b == 4'd4, "wrap_wc_b", wc_b, 4);
        wait_idle(50);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
